// File: rtl/score_disp_pkg.sv
// Shared constants and helpers for the BCD score display: the active-low
// 7-segment glyph table and a single-digit BCD adder used by the accumulator.
package score_disp_pkg;

   // Segment order {dp,g,f,e,d,c,b,a}, active-low, decimal point off.
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DIGIT [0:9] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

   // Adds a value (0..9 for the units digit, 0/1 ripple carry elsewhere) to one
   // BCD nibble. Returns {carry_out, nibble}.
   function automatic logic [4:0] bcd_add_digit(input logic [3:0] nibble,
                                                input logic [3:0] carry_in);
      logic [4:0] sum;
      sum = {1'b0, nibble} + {1'b0, carry_in};
      if (sum > 5'd9) begin
         return {1'b1, 4'(sum - 5'd10)};
      end
      return {1'b0, sum[3:0]};
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low 7-segment pattern.
// Nibbles outside 0..9 produce a blank digit.
module seg7_decoder (
   input  logic [3:0] bcd,
   output logic [7:0] seg
);
   import score_disp_pkg::*;

   // Table lookup with blank fallback for non-BCD codes.
   always_comb begin
      seg = SEG_BLANK;
      if (bcd <= 4'd9) begin
         seg = SEG_DIGIT[bcd];
      end
   end

endmodule

// File: rtl/bcd_score_display.sv
// Score counter with multiplexed common-anode 7-segment driver.
// Rising edges of add_cube add min(add_amt,9) to a BCD score that saturates
// at all 9s (setting a sticky overflow flag). The display scans one digit
// every SCAN_DIV cycles; sel and seg_out are registered together.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown).
module bcd_score_display #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    add_cube,
   input  logic [3:0]              add_amt,
   output logic [7:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   sel,
   output logic [4*NUM_DIGITS-1:0] score_bcd,
   output logic                    overflow
);
   import score_disp_pkg::*;

   localparam int SCORE_W = 4 * NUM_DIGITS;
   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int IDX_N   = 1 << IDX_W;
   localparam int CNT_W   = $clog2(SCAN_DIV);
   localparam logic [NUM_DIGITS-1:0] RESET_SEL = ~(NUM_DIGITS'(1) << (NUM_DIGITS - 1));
   localparam logic [SCORE_W-1:0]    ALL_NINES = {NUM_DIGITS{4'h9}};

   logic [SCORE_W-1:0]    score_reg;
   logic                  overflow_reg;
   logic                  add_q_reg;
   logic [CNT_W-1:0]      cnt_reg;
   logic [IDX_W-1:0]      idx_reg;
   logic [NUM_DIGITS-1:0] sel_reg;
   logic [7:0]            seg_reg;

   logic                  add_event;
   logic [3:0]            amt_sat;
   logic [SCORE_W-1:0]    sum_bcd;
   logic [NUM_DIGITS:1]   carry;
   logic                  scan_last;
   logic [IDX_W-1:0]      idx_next;
   logic [NUM_DIGITS-1:0] sel_next;
   logic [7:0]            seg_next;
   logic [7:0]            dec_seg;
   logic [3:0]            digit_arr [IDX_N];

   assign add_event = add_cube & ~add_q_reg;
   assign amt_sat   = (add_amt > 4'd9) ? 4'd9 : add_amt;
   assign scan_last = (cnt_reg == CNT_W'(SCAN_DIV - 1));
   assign idx_next  = (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);

   // Ripple-carry BCD adder: the amount enters at the units digit, carries
   // propagate upward; a carry out of the top digit means saturation.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_add
         logic [4:0] add_res;
         if (gi == 0) begin : g_units
            assign add_res = bcd_add_digit(score_reg[3:0], amt_sat);
         end else begin : g_upper
            assign add_res = bcd_add_digit(score_reg[4*gi +: 4], {3'b000, carry[gi]});
         end
         assign sum_bcd[4*gi +: 4] = add_res[3:0];
         assign carry[gi+1]        = add_res[4];
      end
   endgenerate

   // Digit view of the score, padded to a power of two for safe indexing.
   generate
      for (genvar gi = 0; gi < IDX_N; gi++) begin : g_digit
         if (gi < NUM_DIGITS) begin : g_real
            assign digit_arr[gi] = score_reg[4*gi +: 4];
         end else begin : g_pad
            assign digit_arr[gi] = 4'hF;
         end
      end
   endgenerate

   // Active-low one-hot select: digit 0 (units) drives the top sel bit.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
         assign sel_next[gi] = (idx_next != IDX_W'(NUM_DIGITS - 1 - gi));
      end
   endgenerate

   seg7_decoder u_dec (
      .bcd (digit_arr[idx_next]),
      .seg (dec_seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   logic [IDX_N-1:0] lead_zero;
   logic             blank_next;

   // A digit is a leading zero when it and every higher digit are zero.
   generate
      for (genvar gi = 0; gi < IDX_N; gi++) begin : g_lz
         if (gi < NUM_DIGITS) begin : g_real
            assign lead_zero[gi] = (score_reg[SCORE_W-1:4*gi] == '0);
         end else begin : g_pad
            assign lead_zero[gi] = 1'b1;
         end
      end
   endgenerate

   assign blank_next = (idx_next != '0) && lead_zero[idx_next];
   assign seg_next   = blank_next ? SEG_BLANK : dec_seg;
`else
   assign seg_next   = dec_seg;
`endif

   // Edge detector and saturating BCD score accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         score_reg    <= '0;
         overflow_reg <= 1'b0;
         add_q_reg    <= 1'b0;
      end else if (clear) begin
         // Clear drops a coincident event but still tracks the level,
         // so holding add_cube high afterwards does not score.
         score_reg    <= '0;
         overflow_reg <= 1'b0;
         add_q_reg    <= add_cube;
      end else begin
         add_q_reg <= add_cube;
         if (add_event) begin
            if (carry[NUM_DIGITS]) begin
               score_reg    <= ALL_NINES;
               overflow_reg <= 1'b1;
            end else begin
               score_reg    <= sum_bcd;
            end
         end
      end
   end

   // Scan divider, digit index and registered display outputs.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_reg <= '0;
         idx_reg <= '0;
         sel_reg <= RESET_SEL;
         seg_reg <= SEG_DIGIT[0];
      end else begin
         cnt_reg <= scan_last ? '0 : cnt_reg + CNT_W'(1);
         if (scan_last) begin
            idx_reg <= idx_next;
            sel_reg <= sel_next;
            seg_reg <= seg_next;
         end
      end
   end

   assign score_bcd = score_reg;
   assign overflow  = overflow_reg;
   assign sel       = sel_reg;
   assign seg_out   = seg_reg;

endmodule
